// File: rtl/rv_exec_datapath.sv
// Execute-stage slice of the single-cycle RV32 core: register file, immediate
// extender, operand-B mux and ALU with a Zero flag for branch resolution.
module rv_exec_datapath #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            RFWr,
  input  logic [4:0]      A1,
  input  logic [4:0]      A2,
  input  logic [4:0]      A3,
  input  logic [XLEN-1:0] WD,
  input  logic [4:0]      iimm_shamt,
  input  logic [11:0]     iimm,
  input  logic [11:0]     simm,
  input  logic [11:0]     bimm,
  input  logic [19:0]     uimm,
  input  logic [19:0]     jimm,
  input  logic [2:0]      EXTOp,
  input  logic            ALUSrc,
  input  logic [4:0]      ALUOp,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic [XLEN-1:0] immout,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] aluout,
  output logic            Zero,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [4:0] OP_NOP  = 5'd0,  OP_LUI  = 5'd1,  OP_ADD  = 5'd2,
                         OP_SUB  = 5'd3,  OP_AND  = 5'd4,  OP_OR   = 5'd5,
                         OP_XOR  = 5'd6,  OP_SLL  = 5'd7,  OP_SRL  = 5'd8,
                         OP_SRA  = 5'd9,  OP_SLT  = 5'd10, OP_SLTU = 5'd11,
                         OP_BEQ  = 5'd12, OP_BNE  = 5'd13, OP_BLT  = 5'd14,
                         OP_BGE  = 5'd15, OP_BLTU = 5'd16, OP_BGEU = 5'd17;

  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (RFWr && A3 != 5'd0) regs_d[A3] = WD;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  // x0 is hardwired; reads see the pre-edge value (no write bypass).
  assign RD1      = (A1 == 5'd0)       ? '0 : regs_q[A1];
  assign RD2      = (A2 == 5'd0)       ? '0 : regs_q[A2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

  always_comb begin
    immout = '0;
    case (EXTOp)
      3'd0: immout = {{(XLEN-12){iimm[11]}}, iimm};
      3'd1: immout = {{(XLEN-12){simm[11]}}, simm};
      3'd2: immout = {{(XLEN-13){bimm[11]}}, bimm, 1'b0};
      3'd3: immout = {uimm, 12'b0};
      3'd4: immout = {{(XLEN-21){jimm[19]}}, jimm, 1'b0};
      3'd5: immout = {{(XLEN-5){1'b0}}, iimm_shamt};
      default: immout = '0;
    endcase
  end

  assign alu_a = RD1;
  assign alu_b = ALUSrc ? immout : RD2;

  logic [4:0] shamt;
  logic       eq, lt_s, lt_u;
  assign shamt = alu_b[4:0];
  assign eq    = (alu_a == alu_b);
  assign lt_s  = ($signed(alu_a) < $signed(alu_b));
  assign lt_u  = (alu_a < alu_b);

  // Branch ops return 0 when taken so that Zero doubles as the take signal.
  always_comb begin
    aluout = '0;
    case (ALUOp)
      OP_NOP:  aluout = alu_a;
      OP_LUI:  aluout = alu_b;
      OP_ADD:  aluout = alu_a + alu_b;
      OP_SUB:  aluout = alu_a - alu_b;
      OP_AND:  aluout = alu_a & alu_b;
      OP_OR:   aluout = alu_a | alu_b;
      OP_XOR:  aluout = alu_a ^ alu_b;
      OP_SLL:  aluout = alu_a << shamt;
      OP_SRL:  aluout = alu_a >> shamt;
      OP_SRA:  aluout = $unsigned($signed(alu_a) >>> shamt);
      OP_SLT:  aluout = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: aluout = {{(XLEN-1){1'b0}}, lt_u};
      OP_BEQ:  aluout = {{(XLEN-1){1'b0}}, ~eq};
      OP_BNE:  aluout = {{(XLEN-1){1'b0}}, eq};
      OP_BLT:  aluout = {{(XLEN-1){1'b0}}, ~lt_s};
      OP_BGE:  aluout = {{(XLEN-1){1'b0}}, lt_s};
      OP_BLTU: aluout = {{(XLEN-1){1'b0}}, ~lt_u};
      OP_BGEU: aluout = {{(XLEN-1){1'b0}}, lt_u};
      default: aluout = '0;
    endcase
  end

  assign Zero = (aluout == '0);

endmodule

// File: tb/tb_rv_exec_datapath.sv
// Directed bench for rv_exec_datapath: register file, extender, operand mux,
// ALU ops, branch compares and asynchronous reset.
module tb_rv_exec_datapath;
  logic        clk = 1'b0;
  logic        rstn;
  logic        RFWr;
  logic [4:0]  A1, A2, A3, iimm_shamt, ALUOp, dbg_addr;
  logic [31:0] WD;
  logic [11:0] iimm, simm, bimm;
  logic [19:0] uimm, jimm;
  logic [2:0]  EXTOp;
  logic        ALUSrc;
  logic [31:0] RD1, RD2, immout, alu_a, alu_b, aluout, dbg_data;
  logic        Zero;

  int errs = 0;
  int chks = 0;

  rv_exec_datapath #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rstn(rstn), .RFWr(RFWr), .A1(A1), .A2(A2), .A3(A3), .WD(WD),
    .iimm_shamt(iimm_shamt), .iimm(iimm), .simm(simm), .bimm(bimm),
    .uimm(uimm), .jimm(jimm), .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .dbg_addr(dbg_addr), .RD1(RD1), .RD2(RD2), .immout(immout),
    .alu_a(alu_a), .alu_b(alu_b), .aluout(aluout), .Zero(Zero),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    RFWr = 1'b1; A3 = a; WD = d;
    @(posedge clk); #1;
    RFWr = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #3;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(i); dbg_addr = 5'(i);
      #1;
      chks++;
      if (RD1 !== 32'h0 || RD2 !== 32'h0 || dbg_data !== 32'h0) begin
        errs++;
        $display("FAIL reset_read[%0d] got RD1=%h RD2=%h dbg=%h want 0", i, RD1, RD2, dbg_data);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_write;
    write_reg(5'd5, 32'hDEADBEEF);
    A1 = 5'd5; dbg_addr = 5'd5; #1;
    chks++;
    if (RD1 !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_rd1 got %h want deadbeef", RD1); end
    chks++;
    if (dbg_data !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_dbg got %h want deadbeef", dbg_data); end

    // Pending write must not be visible before the edge.
    @(negedge clk);
    RFWr = 1'b1; A3 = 5'd6; WD = 32'hCAFEF00D; A2 = 5'd6; #1;
    chks++;
    if (RD2 !== 32'h0) begin errs++; $display("FAIL no_bypass got %h want 0", RD2); end
    @(posedge clk); #1;
    RFWr = 1'b0;
    chks++;
    if (RD2 !== 32'hCAFEF00D) begin errs++; $display("FAIL after_edge got %h want cafef00d", RD2); end

    write_reg(5'd0, 32'h1234);
    A1 = 5'd0; #1;
    chks++;
    if (RD1 !== 32'h0) begin errs++; $display("FAIL x0_write got %h want 0", RD1); end

    @(negedge clk);
    RFWr = 1'b0; A3 = 5'd5; WD = 32'h55555555;
    @(posedge clk); #1;
    A1 = 5'd5; #1;
    chks++;
    if (RD1 !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_disabled got %h want deadbeef", RD1); end
  endtask

  task automatic test_ext;
    logic [2:0]  ops [8];
    logic [31:0] exp [8];
    iimm = 12'hFFF; simm = 12'h7FF; bimm = 12'h800; uimm = 20'h12345;
    jimm = 20'h00001; iimm_shamt = 5'd31;
    ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    exp = '{32'hFFFFFFFF, 32'h000007FF, 32'hFFFFF000, 32'h12345000,
            32'h00000002, 32'h0000001F, 32'h0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      EXTOp = ops[i]; #1;
      chks++;
      if (immout !== exp[i]) begin
        errs++; $display("FAIL ext_op%0d got %h want %h", ops[i], immout, exp[i]);
      end
    end
    // Negative J immediate exercises the 21-bit sign extension.
    EXTOp = 3'd4; jimm = 20'h80000; #1;
    chks++;
    if (immout !== 32'hFFF00000) begin errs++; $display("FAIL ext_jneg got %h want fff00000", immout); end
  endtask

  task automatic test_alu;
    logic [4:0]  a1s [14];
    logic [4:0]  a2s [14];
    logic [4:0]  ops [14];
    logic [31:0] exp [14];
    write_reg(5'd1, 32'h00000007);
    write_reg(5'd2, 32'hFFFFFFF9);
    write_reg(5'd3, 32'h80000000);
    write_reg(5'd4, 32'h00000004);
    write_reg(5'd11, 32'hFFFFFFE4); // low five bits = 4
    ALUSrc = 1'b0;
    a1s = '{5'd1, 5'd1, 5'd1, 5'd2, 5'd1, 5'd3, 5'd3, 5'd3, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
    a2s = '{5'd2, 5'd2, 5'd2, 5'd1, 5'd2, 5'd4, 5'd4, 5'd11, 5'd4, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2};
    ops = '{5'd2, 5'd3, 5'd10, 5'd10, 5'd11, 5'd9, 5'd8, 5'd9, 5'd7,
            5'd4, 5'd5, 5'd6, 5'd0, 5'd1};
    exp = '{32'h00000000, 32'h0000000E, 32'h00000000, 32'h00000001,
            32'h00000001, 32'hF8000000, 32'h08000000, 32'hF8000000,
            32'h00000070, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFE,
            32'h00000007, 32'hFFFFFFF9};
    for (int i = 0; i < 14; i++) begin
      A1 = a1s[i]; A2 = a2s[i]; ALUOp = ops[i]; #1;
      chks++;
      if (aluout !== exp[i] || Zero !== (exp[i] == 32'h0)) begin
        errs++;
        $display("FAIL alu[%0d] op%0d got %h Z=%b want %h", i, ops[i], aluout, Zero, exp[i]);
      end
    end
    ALUOp = 5'd20; A1 = 5'd1; #1;
    chks++;
    if (aluout !== 32'h0 || Zero !== 1'b1) begin errs++; $display("FAIL alu_op20 got %h Z=%b want 0 Z=1", aluout, Zero); end
  endtask

  task automatic test_branch;
    logic [4:0] a1s [8];
    logic [4:0] a2s [8];
    logic [4:0] ops [8];
    logic       zx  [8];
    write_reg(5'd6, 32'd5);
    write_reg(5'd7, 32'd5);
    write_reg(5'd8, 32'hFFFFFFFF);
    write_reg(5'd9, 32'd1);
    ALUSrc = 1'b0;
    a1s = '{5'd6, 5'd6, 5'd8, 5'd8, 5'd8, 5'd8, 5'd9, 5'd9};
    a2s = '{5'd7, 5'd7, 5'd9, 5'd9, 5'd9, 5'd9, 5'd8, 5'd8};
    ops = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd16, 5'd12};
    zx  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      A1 = a1s[i]; A2 = a2s[i]; ALUOp = ops[i]; #1;
      chks++;
      if (Zero !== zx[i] || aluout !== {31'b0, ~zx[i]}) begin
        errs++;
        $display("FAIL branch[%0d] op%0d got Z=%b C=%h want Z=%b", i, ops[i], Zero, aluout, zx[i]);
      end
    end
  endtask

  task automatic test_alusrc;
    write_reg(5'd10, 32'd100);
    A1 = 5'd10; A2 = 5'd1; ALUSrc = 1'b1; EXTOp = 3'd0; iimm = 12'hFFC;
    ALUOp = 5'd2; #1;
    chks++;
    if (aluout !== 32'd96) begin errs++; $display("FAIL alusrc_add got %h want 00000060", aluout); end
    chks++;
    if (alu_b !== 32'hFFFFFFFC) begin errs++; $display("FAIL alusrc_b got %h want fffffffc", alu_b); end
    chks++;
    if (alu_a !== 32'd100) begin errs++; $display("FAIL alusrc_a got %h want 00000064", alu_a); end
    ALUSrc = 1'b0; #1;
    chks++;
    if (alu_b !== 32'h7 || aluout !== 32'd107) begin errs++; $display("FAIL alusrc0 got b=%h c=%h want 7/6b", alu_b, aluout); end
  endtask

  task automatic test_async_reset;
    A1 = 5'd10; A2 = 5'd5; dbg_addr = 5'd1;
    @(posedge clk); #2;
    rstn = 1'b0; #1;
    chks++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0 || dbg_data !== 32'h0) begin
      errs++; $display("FAIL async_rst got %h %h %h want 0", RD1, RD2, dbg_data);
    end
    // Writes are blocked while reset is held.
    RFWr = 1'b1; A3 = 5'd10; WD = 32'hA5A5A5A5;
    @(posedge clk); #1;
    RFWr = 1'b0;
    chks++;
    if (RD1 !== 32'h0) begin errs++; $display("FAIL rst_hold got %h want 0", RD1); end
    @(negedge clk);
    rstn = 1'b1; #1;
    chks++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0 || dbg_data !== 32'h0) begin
      errs++; $display("FAIL rst_release got %h %h %h want 0", RD1, RD2, dbg_data);
    end
  endtask

  initial begin
    rstn = 1'b0; RFWr = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD = '0;
    iimm_shamt = '0; iimm = '0; simm = '0; bimm = '0; uimm = '0; jimm = '0;
    EXTOp = '0; ALUSrc = 1'b0; ALUOp = '0; dbg_addr = '0;
    test_reset;
    test_write;
    test_ext;
    test_alu;
    test_branch;
    test_alusrc;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
